// File: rtl/rx_pkt_buffer_pkg.sv
// Shared types for the receive packet buffer: stored word layout, write FSM states, byte helper.
package rx_pkt_buffer_pkg;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned MOD_W  = 3;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              sop;
        logic              eop;
        logic [MOD_W-1:0]  mod;
    } rx_word_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IN_PKT = 2'd1,
        COMMIT = 2'd2,
        DROP   = 2'd3
    } wr_state_t;

    // Valid bytes carried by one word; mod 0 on an eop word means a full word.
    function automatic logic [3:0] bytes_in_word(input logic eop, input logic [MOD_W-1:0] mod);
        if (eop && (mod != '0)) begin
            return 4'(mod);
        end
        return 4'd8;
    endfunction

endpackage

// File: rtl/rx_pkt_buffer_if.sv
// MAC-facing receive bus and host-facing output stream of rx_pkt_buffer.
// Statistics outputs exist only when RX_PKT_BUFFER_STATS_EN is defined.
interface rx_pkt_buffer_if;
    import rx_pkt_buffer_pkg::*;

    logic [DATA_W-1:0] pkt_rx_data;
    logic              pkt_rx_sop;
    logic              pkt_rx_eop;
    logic [MOD_W-1:0]  pkt_rx_mod;
    logic              pkt_rx_val;
    logic              pkt_rx_full;

    logic [DATA_W-1:0] out_data;
    logic              out_sop;
    logic              out_eop;
    logic [MOD_W-1:0]  out_mod;
    logic              out_val;
    logic              out_ready;

`ifdef RX_PKT_BUFFER_STATS_EN
    logic [31:0] stat_good_pkts;
    logic [31:0] stat_drop_pkts;
    logic [31:0] stat_orphan_words;
    logic [47:0] stat_good_bytes;
`endif

    // master: MAC plus host consumer; slave: the buffer
    modport master (
        output pkt_rx_data, pkt_rx_sop, pkt_rx_eop, pkt_rx_mod, pkt_rx_val, out_ready,
`ifdef RX_PKT_BUFFER_STATS_EN
        input  stat_good_pkts, stat_drop_pkts, stat_orphan_words, stat_good_bytes,
`endif
        input  pkt_rx_full, out_data, out_sop, out_eop, out_mod, out_val
    );

    modport slave (
        input  pkt_rx_data, pkt_rx_sop, pkt_rx_eop, pkt_rx_mod, pkt_rx_val, out_ready,
`ifdef RX_PKT_BUFFER_STATS_EN
        output stat_good_pkts, stat_drop_pkts, stat_orphan_words, stat_good_bytes,
`endif
        output pkt_rx_full, out_data, out_sop, out_eop, out_mod, out_val
    );

endinterface

// File: rtl/rx_pkt_buffer_ram.sv
// Simple dual-port word store: synchronous write, registered read whose output
// register holds its value until the next read enable.
module rx_pkt_buffer_ram
    import rx_pkt_buffer_pkg::*;
#(
    parameter  int unsigned DEPTH = 256,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  rx_word_t      wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output rx_word_t      rdata
);

    rx_word_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read register doubles as the output stage, so it carries a reset value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/rx_pkt_buffer.sv
// Store-and-forward receive packet buffer: commits only complete, well-formed packets.
// Optional statistics counters are built when RX_PKT_BUFFER_STATS_EN is defined.
module rx_pkt_buffer
    import rx_pkt_buffer_pkg::*;
#(
    parameter int unsigned DEPTH         = 256,
    parameter int unsigned AFULL_MARGIN  = 8,
    parameter int unsigned MAX_PKT_WORDS = 200
) (
    input  logic          clk_156m25,
    input  logic          reset_156m25,
    rx_pkt_buffer_if.slave bus
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned CW = $clog2(MAX_PKT_WORDS + 1);

    wr_state_t      state, state_nxt;
    logic [PW-1:0]  wr_ptr, wr_ptr_nxt;
    logic [PW-1:0]  commit_ptr, commit_ptr_nxt;
    logic [PW-1:0]  rd_ptr;
    logic [CW-1:0]  word_cnt, word_cnt_nxt;
    logic           full;
    logic           out_val;

    logic [PW-1:0]  used_c;
    logic [PW-1:0]  base_c;
    logic [AW-1:0]  waddr_c;
    logic           we_c;
    logic           start_c;
    logic           good_c;
    logic           orphan_c;
    logic [1:0]     drop_inc_c;
    rx_word_t       wdata_c;
    rx_word_t       rdata;

    logic           handshake_c;
    logic [PW-1:0]  rd_next_c;
    logic           re_c;

    assign used_c  = wr_ptr - rd_ptr;
    assign wdata_c = '{data: bus.pkt_rx_data,
                       sop:  bus.pkt_rx_sop,
                       eop:  bus.pkt_rx_eop,
                       mod:  bus.pkt_rx_eop ? bus.pkt_rx_mod : '0};

    // Write FSM next state; a sop arriving in IDLE, COMMIT or mid-packet funnels into start_c
    always_comb begin
        state_nxt      = state;
        wr_ptr_nxt     = wr_ptr;
        commit_ptr_nxt = commit_ptr;
        word_cnt_nxt   = word_cnt;
        base_c         = wr_ptr;
        waddr_c        = wr_ptr[AW-1:0];
        we_c           = 1'b0;
        start_c        = 1'b0;
        good_c         = 1'b0;
        orphan_c       = 1'b0;
        drop_inc_c     = 2'd0;

        if (state == COMMIT) begin
            commit_ptr_nxt = wr_ptr;
            state_nxt      = IDLE;
        end

        case (state)
            IDLE, COMMIT: begin
                if (bus.pkt_rx_val) begin
                    if (bus.pkt_rx_sop) begin
                        start_c = 1'b1;
                    end else begin
                        orphan_c = 1'b1;
                    end
                end
            end
            IN_PKT: begin
                if (bus.pkt_rx_val) begin
                    if (bus.pkt_rx_sop) begin
                        // Unterminated packet: rewind, then restart from the committed point
                        drop_inc_c = 2'd1;
                        base_c     = commit_ptr;
                        start_c    = 1'b1;
                    end else if (used_c == PW'(DEPTH)) begin
                        drop_inc_c = 2'd1;
                        wr_ptr_nxt = commit_ptr;
                        state_nxt  = bus.pkt_rx_eop ? IDLE : DROP;
                    end else begin
                        we_c         = 1'b1;
                        wr_ptr_nxt   = wr_ptr + PW'(1);
                        word_cnt_nxt = word_cnt + CW'(1);
                        if (bus.pkt_rx_eop) begin
                            good_c    = 1'b1;
                            state_nxt = COMMIT;
                        end else if (word_cnt_nxt == CW'(MAX_PKT_WORDS)) begin
                            drop_inc_c = 2'd1;
                            wr_ptr_nxt = commit_ptr;
                            state_nxt  = DROP;
                        end
                    end
                end
            end
            DROP: begin
                if (bus.pkt_rx_val && bus.pkt_rx_eop) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (start_c) begin
            if (PW'(base_c - rd_ptr) == PW'(DEPTH)) begin
                drop_inc_c = drop_inc_c + 2'd1;
                wr_ptr_nxt = base_c;
                state_nxt  = bus.pkt_rx_eop ? IDLE : DROP;
            end else begin
                we_c         = 1'b1;
                waddr_c      = base_c[AW-1:0];
                wr_ptr_nxt   = base_c + PW'(1);
                word_cnt_nxt = CW'(1);
                if (bus.pkt_rx_eop) begin
                    good_c    = 1'b1;
                    state_nxt = COMMIT;
                end else begin
                    state_nxt = IN_PKT;
                end
            end
        end
    end

    always_ff @(posedge clk_156m25 or posedge reset_156m25) begin
        if (reset_156m25) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Read side: the RAM read register is the output stage; fetch when it is empty or being drained
    assign handshake_c = out_val & bus.out_ready;
    assign rd_next_c   = rd_ptr + PW'(handshake_c);
    assign re_c        = (!out_val || handshake_c) && (commit_ptr != rd_next_c);

    always_ff @(posedge clk_156m25 or posedge reset_156m25) begin
        if (reset_156m25) begin
            wr_ptr     <= '0;
            commit_ptr <= '0;
            rd_ptr     <= '0;
            word_cnt   <= '0;
            full       <= 1'b0;
            out_val    <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr_nxt;
            commit_ptr <= commit_ptr_nxt;
            rd_ptr     <= rd_next_c;
            word_cnt   <= word_cnt_nxt;
            full       <= (PW'(DEPTH) - used_c) <= PW'(AFULL_MARGIN);
            out_val    <= re_c | (out_val & ~handshake_c);
        end
    end

    rx_pkt_buffer_ram #(.DEPTH(DEPTH)) u_ram (
        .clk   (clk_156m25),
        .rst   (reset_156m25),
        .we    (we_c),
        .waddr (waddr_c),
        .wdata (wdata_c),
        .re    (re_c),
        .raddr (rd_next_c[AW-1:0]),
        .rdata (rdata)
    );

    assign bus.pkt_rx_full = full;
    assign bus.out_val     = out_val;
    assign bus.out_data    = rdata.data;
    assign bus.out_sop     = rdata.sop;
    assign bus.out_eop     = rdata.eop;
    assign bus.out_mod     = rdata.mod;

`ifdef RX_PKT_BUFFER_STATS_EN
    localparam int unsigned PB_W = $clog2(MAX_PKT_WORDS * 8 + 1);

    logic [PB_W-1:0] pkt_bytes;
    logic [PB_W-1:0] pkt_bytes_cur_c;
    logic [31:0]     good_pkts, drop_pkts, orphan_words;
    logic [47:0]     good_bytes;
    logic [32:0]     good_pkts_sum_c, drop_pkts_sum_c, orphan_sum_c;
    logic [48:0]     good_bytes_sum_c;

    // One spare carry bit per counter detects saturation
    always_comb begin
        pkt_bytes_cur_c  = (start_c ? '0 : pkt_bytes)
                         + PB_W'(bytes_in_word(bus.pkt_rx_eop, bus.pkt_rx_mod));
        good_pkts_sum_c  = {1'b0, good_pkts} + 33'(good_c);
        drop_pkts_sum_c  = {1'b0, drop_pkts} + 33'(drop_inc_c);
        orphan_sum_c     = {1'b0, orphan_words} + 33'(orphan_c);
        good_bytes_sum_c = {1'b0, good_bytes} + 49'(pkt_bytes_cur_c);
    end

    always_ff @(posedge clk_156m25 or posedge reset_156m25) begin
        if (reset_156m25) begin
            pkt_bytes    <= '0;
            good_pkts    <= '0;
            drop_pkts    <= '0;
            orphan_words <= '0;
            good_bytes   <= '0;
        end else begin
            if (we_c) begin
                pkt_bytes <= pkt_bytes_cur_c;
            end
            good_pkts    <= good_pkts_sum_c[32] ? '1 : good_pkts_sum_c[31:0];
            drop_pkts    <= drop_pkts_sum_c[32] ? '1 : drop_pkts_sum_c[31:0];
            orphan_words <= orphan_sum_c[32]    ? '1 : orphan_sum_c[31:0];
            if (good_c) begin
                good_bytes <= good_bytes_sum_c[48] ? '1 : good_bytes_sum_c[47:0];
            end
        end
    end

    assign bus.stat_good_pkts    = good_pkts;
    assign bus.stat_drop_pkts    = drop_pkts;
    assign bus.stat_orphan_words = orphan_words;
    assign bus.stat_good_bytes   = good_bytes;
`endif

endmodule

// File: tb/tb_rx_pkt_buffer.sv
// Randomized bench for rx_pkt_buffer against a queue-level packet model.
module tb_rx_pkt_buffer;
    import rx_pkt_buffer_pkg::*;

    localparam int DEPTH         = 256;
    localparam int AFULL_MARGIN  = 8;
    localparam int MAX_PKT_WORDS = 200;
    localparam int M_IDLE = 0;
    localparam int M_IN   = 1;
    localparam int M_DROP = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rx_pkt_buffer_if bus ();

    rx_pkt_buffer #(
        .DEPTH         (DEPTH),
        .AFULL_MARGIN  (AFULL_MARGIN),
        .MAX_PKT_WORDS (MAX_PKT_WORDS)
    ) dut (
        .clk_156m25   (clk),
        .reset_156m25 (rst),
        .bus          (bus)
    );

    // Model: words awaiting delivery, the packet being received, and receive mode
    rx_word_t exp_q[$];
    rx_word_t part_q[$];
    int       mode          = M_IDLE;
    logic     pred_full     = 1'b0;
    int       rdy_mode      = 1;
    int       cyc           = 0;
    int       first_val_cyc = -1;
    int       eop_cyc       = 0;
    bit       saw_full      = 1'b0;
    int       n_checks      = 0;
    int       n_pass        = 0;
    longint unsigned m_good = 0, m_drop = 0, m_orphan = 0, m_bytes = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: observed 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic m_commit();
        rx_word_t last;
        last = part_q[part_q.size() - 1];
        m_good++;
        m_bytes += longint'(8 * (part_q.size() - 1));
        m_bytes += (last.mod == 3'd0) ? 64'd8 : 64'(last.mod);
        foreach (part_q[i]) exp_q.push_back(part_q[i]);
        part_q.delete();
        mode = M_IDLE;
    endtask

    task automatic m_start(input rx_word_t w, input int used);
        part_q.delete();
        if (used == DEPTH) begin
            m_drop++;
            mode = w.eop ? M_IDLE : M_DROP;
        end else begin
            part_q.push_back(w);
            if (w.eop) m_commit();
            else mode = M_IN;
        end
    endtask

    // One clock: check outputs, drive inputs, advance the model
    task automatic cycle(input logic val, input logic sop, input logic eop,
                         input logic [2:0] mod, input logic [63:0] data);
        int used, pre;
        logic rdy, hs;
        rx_word_t w;
        @(negedge clk);
        cyc++;
        check("pkt_rx_full", 128'(bus.pkt_rx_full), 128'(pred_full));
        if (bus.pkt_rx_full) saw_full = 1'b1;
        if (exp_q.size() == 0) begin
            check("out_val_idle", 128'(bus.out_val), 128'(0));
        end else if (bus.out_val) begin
            if (first_val_cyc < 0) first_val_cyc = cyc;
            check("out_word", 128'({bus.out_data, bus.out_sop, bus.out_eop, bus.out_mod}),
                  128'(exp_q[0]));
        end
        case (rdy_mode)
            0:       rdy = 1'b0;
            1:       rdy = 1'b1;
            2:       rdy = cyc[0];
            default: rdy = 1'($urandom_range(0, 1));
        endcase
        bus.pkt_rx_val  = val;
        bus.pkt_rx_sop  = sop;
        bus.pkt_rx_eop  = eop;
        bus.pkt_rx_mod  = mod;
        bus.pkt_rx_data = data;
        bus.out_ready   = rdy;
        hs   = bus.out_val & rdy;
        pre  = exp_q.size();
        used = pre + part_q.size();
        pred_full = (DEPTH - used) <= AFULL_MARGIN;
        if (val) begin
            w = '{data: data, sop: sop, eop: eop, mod: eop ? mod : 3'd0};
            case (mode)
                M_IDLE: begin
                    if (sop) m_start(w, used);
                    else m_orphan++;
                end
                M_IN: begin
                    if (sop) begin
                        m_drop++;
                        m_start(w, pre);
                    end else if (used == DEPTH) begin
                        m_drop++;
                        part_q.delete();
                        mode = eop ? M_IDLE : M_DROP;
                    end else begin
                        part_q.push_back(w);
                        if (eop) m_commit();
                        else if (part_q.size() == MAX_PKT_WORDS) begin
                            m_drop++;
                            part_q.delete();
                            mode = M_DROP;
                        end
                    end
                end
                default: if (eop) mode = M_IDLE;
            endcase
        end
        if (hs && pre > 0) void'(exp_q.pop_front());
    endtask

    task automatic send_pkt(input int n, input logic [2:0] mod, input bit term);
        for (int i = 0; i < n; i++)
            cycle(1'b1, i == 0, term && (i == n - 1), mod, rnd64());
    endtask

    task automatic drain(input int budget, input int rm);
        int k;
        k = 0;
        rdy_mode = rm;
        while (exp_q.size() != 0 && k < budget) begin
            cycle(1'b0, 1'b0, 1'b0, 3'd0, 64'd0);
            k++;
        end
        check("drain_empty", 128'(exp_q.size()), 128'(0));
        repeat (3) cycle(1'b0, 1'b0, 1'b0, 3'd0, 64'd0);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        bus.pkt_rx_val = 1'b0;
        bus.out_ready  = 1'b0;
        exp_q.delete();
        part_q.delete();
        mode = M_IDLE;
        pred_full = 1'b0;
        m_good = 0; m_drop = 0; m_orphan = 0; m_bytes = 0;
        repeat (n) begin
            @(negedge clk);
            check("out_val_in_reset", 128'(bus.out_val), 128'(0));
        end
        rst = 1'b0;
    endtask

    task automatic check_stats();
`ifdef RX_PKT_BUFFER_STATS_EN
        check("stat_good_pkts", 128'(bus.stat_good_pkts), 128'(m_good));
        check("stat_drop_pkts", 128'(bus.stat_drop_pkts), 128'(m_drop));
        check("stat_orphan_words", 128'(bus.stat_orphan_words), 128'(m_orphan));
        check("stat_good_bytes", 128'(bus.stat_good_bytes), 128'(m_bytes));
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
        $fatal(1);
    end

    initial begin
        bus.pkt_rx_val  = 1'b0;
        bus.pkt_rx_sop  = 1'b0;
        bus.pkt_rx_eop  = 1'b0;
        bus.pkt_rx_mod  = 3'd0;
        bus.pkt_rx_data = 64'd0;
        bus.out_ready   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out_val", 128'(bus.out_val), 128'(0));
        check("rst_out_sop", 128'(bus.out_sop), 128'(0));
        check("rst_out_eop", 128'(bus.out_eop), 128'(0));
        check("rst_out_mod", 128'(bus.out_mod), 128'(0));
        check("rst_out_data", 128'(bus.out_data), 128'(0));
        check("rst_full", 128'(bus.pkt_rx_full), 128'(0));
        check_stats();
        rst = 1'b0;

        // Two-word packet and first-word latency
        rdy_mode = 1;
        cycle(1'b1, 1'b1, 1'b0, 3'd0, 64'h1111_1111_1111_1111);
        first_val_cyc = -1;
        cycle(1'b1, 1'b0, 1'b1, 3'd4, 64'h2222_2222_2222_2222);
        eop_cyc = cyc;
        drain(50, 1);
        check("first_val_latency",
              128'((first_val_cyc - eop_cyc) >= 2 && (first_val_cyc - eop_cyc) <= 3), 128'(1));
        check_stats();

        // Fill with max-length packets while stalled; second one overflows
        saw_full = 1'b0;
        rdy_mode = 0;
        send_pkt(MAX_PKT_WORDS, 3'd5, 1'b1);
        send_pkt(MAX_PKT_WORDS, 3'd2, 1'b1);
        check("full_seen", 128'(saw_full), 128'(1));
        drain(600, 1);
        check_stats();

        // Oversize packet is dropped, buffer keeps working
        send_pkt(MAX_PKT_WORDS + 5, 3'd1, 1'b1);
        send_pkt(3, 3'd6, 1'b1);
        drain(50, 1);

        // sop at word 3 of an unfinished packet
        cycle(1'b1, 1'b1, 1'b0, 3'd0, rnd64());
        cycle(1'b1, 1'b0, 1'b0, 3'd0, rnd64());
        cycle(1'b1, 1'b1, 1'b0, 3'd0, rnd64());
        cycle(1'b1, 1'b0, 1'b1, 3'd7, rnd64());
        drain(50, 1);

        // Orphans then a single-word packet
        repeat (3) cycle(1'b1, 1'b0, 1'b0, 3'd0, rnd64());
        cycle(1'b1, 1'b1, 1'b1, 3'd0, rnd64());
        drain(50, 1);
        check_stats();

        // Five-word packet with a toggling consumer
        rdy_mode = 2;
        send_pkt(5, 3'd3, 1'b1);
        drain(100, 2);

        // Reset mid-packet, then a clean packet
        send_pkt(3, 3'd0, 1'b0);
        do_reset(2);
        rdy_mode = 1;
        send_pkt(4, 3'd2, 1'b1);
        drain(50, 1);
        check_stats();

        // Random traffic
        rdy_mode = 3;
        for (int p = 0; p < 300; p++) begin
            int nw;
            bit abort;
            nw    = int'($urandom_range(1, 12));
            abort = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 9) == 0)
                cycle(1'b1, 1'b0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), rnd64());
            send_pkt(nw, 3'($urandom_range(0, 7)), !abort);
            repeat ($urandom_range(0, 2)) cycle(1'b0, 1'b0, 1'b0, 3'd0, rnd64());
        end
        send_pkt(2, 3'd0, 1'b1);
        drain(3000, 1);
        check_stats();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
